// File: rtl/axi4_lite_read_arbiter.sv
// Round-robin arbiter that funnels several internal read requesters onto one
// AXI4-Lite read master port, one transaction at a time, with a response timeout.
module axi4_lite_read_arbiter #(
    parameter int unsigned ADDRESS_WIDTH  = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned NUM_REQ        = 2,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                             axi_clk,
    input  logic                             resetn,
    input  logic [NUM_REQ-1:0]               req_valid,
    input  logic [NUM_REQ*ADDRESS_WIDTH-1:0] req_addr,
    output logic [NUM_REQ-1:0]               req_ready,
    output logic [NUM_REQ-1:0]               rsp_valid,
    output logic [DATA_WIDTH-1:0]            rsp_data,
    output logic [1:0]                       rsp_resp,
    output logic                             busy,
    output logic [1:0]                       grant_id,
    output logic [ADDRESS_WIDTH-1:0]         araddr,
    output logic                             arvalid,
    input  logic                             arready,
    input  logic [DATA_WIDTH-1:0]            rdata,
    input  logic [1:0]                       rresp,
    input  logic                             rvalid,
    output logic                             rready
);

    localparam int unsigned CNT_W    = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int unsigned CNT_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        DATA,
        RESP,
        DRAIN
    } state_t;

    state_t                   state;
    logic [1:0]               last_grant;
    logic [CNT_W-1:0]         wait_cnt;
    logic                     timeout;

    logic                     win_found;
    logic [1:0]               win_id;
    logic [ADDRESS_WIDTH-1:0] sel_addr;
    logic [NUM_REQ-1:0]       grant_oh;

    // Winner: first requesting index searched cyclically from last_grant+1
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        sel_addr  = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (!win_found && req_valid[i] && (i == (32'(last_grant) + k) % NUM_REQ)) begin
                    win_found = 1'b1;
                    win_id    = 2'(i);
                end
            end
        end
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (32'(win_id) == i) begin
                sel_addr = req_addr[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
            end
        end
    end

    // Acceptance pulse is combinational so the winner sees it in the grant cycle
    always_comb begin
        req_ready = '0;
        grant_oh  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = (state == IDLE) && win_found && (32'(win_id) == i);
            grant_oh[i]  = (32'(grant_id) == i);
        end
    end

    always_ff @(posedge axi_clk) begin
        if (!resetn) begin
            state      <= IDLE;
            last_grant <= 2'(NUM_REQ - 1);
            grant_id   <= '0;
            araddr     <= '0;
            arvalid    <= 1'b0;
            rready     <= 1'b0;
            rsp_valid  <= '0;
            rsp_data   <= '0;
            rsp_resp   <= '0;
            busy       <= 1'b0;
            wait_cnt   <= '0;
            timeout    <= 1'b0;
        end else begin
            rsp_valid <= '0;
            case (state)
                IDLE: begin
                    if (win_found) begin
                        araddr     <= sel_addr;
                        last_grant <= win_id;
                        grant_id   <= win_id;
                        arvalid    <= 1'b1;
                        busy       <= 1'b1;
                        state      <= ADDR;
                    end
                end
                ADDR: begin
                    if (arready) begin
                        arvalid  <= 1'b0;
                        rready   <= 1'b1;
                        wait_cnt <= '0;
                        state    <= DATA;
                    end
                end
                DATA: begin
                    // A beat arriving on the timeout cycle still wins
                    if (rvalid) begin
                        rsp_data  <= rdata;
                        rsp_resp  <= rresp;
                        rready    <= 1'b0;
                        rsp_valid <= grant_oh;
                        state     <= RESP;
                    end else if ((TIMEOUT_CYCLES != 0) && (wait_cnt == CNT_W'(CNT_LAST))) begin
                        timeout   <= 1'b1;
                        rsp_data  <= '0;
                        rsp_resp  <= 2'b10;
                        rready    <= 1'b0;
                        rsp_valid <= grant_oh;
                        state     <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                RESP: begin
                    if (timeout) begin
                        rready <= 1'b1;
                        state  <= DRAIN;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                DRAIN: begin
                    // Swallow the late beat of the timed-out read before reusing the bus
                    if (rvalid) begin
                        timeout <= 1'b0;
                        rready  <= 1'b0;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi4_lite_read_arbiter.sv
// Bench for axi4_lite_read_arbiter: table vectors, reset corner and random
// transactions checked cycle by cycle against a queue-based round-robin model.
module tb_axi4_lite_read_arbiter;

    localparam int NR = 3;
    localparam int TO = 8;
    localparam int AW = 32;
    localparam int DW = 32;

    logic              axi_clk = 1'b0;
    logic              resetn;
    logic [NR-1:0]     req_valid;
    logic [NR*AW-1:0]  req_addr;
    logic [NR-1:0]     req_ready;
    logic [NR-1:0]     rsp_valid;
    logic [DW-1:0]     rsp_data;
    logic [1:0]        rsp_resp;
    logic              busy;
    logic [1:0]        grant_id;
    logic [AW-1:0]     araddr;
    logic              arvalid;
    logic              arready;
    logic [DW-1:0]     rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;

    axi4_lite_read_arbiter #(
        .ADDRESS_WIDTH (AW),
        .DATA_WIDTH    (DW),
        .NUM_REQ       (NR),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .axi_clk  (axi_clk),
        .resetn   (resetn),
        .req_valid(req_valid),
        .req_addr (req_addr),
        .req_ready(req_ready),
        .rsp_valid(rsp_valid),
        .rsp_data (rsp_data),
        .rsp_resp (rsp_resp),
        .busy     (busy),
        .grant_id (grant_id),
        .araddr   (araddr),
        .arvalid  (arvalid),
        .arready  (arready),
        .rdata    (rdata),
        .rresp    (rresp),
        .rvalid   (rvalid),
        .rready   (rready)
    );

    always #5 axi_clk = ~axi_clk;

    typedef struct {
        logic [2:0]  valid;
        int          ar_dly;
        int          r_dly;
        logic [31:0] data;
        logic [1:0]  resp;
        int          exp_g;
    } vec_t;

    vec_t        tbl[11];
    int          errors = 0;
    int          checks = 0;
    int          order[$];
    logic [31:0] a[NR];
    logic [31:0] exp_prev;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    // Priority list: front is highest priority; a winner is rotated to the back
    function automatic void model_reset();
        order = {};
        for (int i = 0; i < NR; i++) order.push_back(i);
    endfunction

    function automatic int model_pick(input logic [2:0] v);
        foreach (order[k]) begin
            if (((v >> order[k]) & 3'd1) != 3'd0) return order[k];
        end
        return -1;
    endfunction

    function automatic void model_commit(input int g);
        while (order[$] != g) order.push_back(order.pop_front());
    endfunction

    function automatic logic [NR*AW-1:0] pack_addr();
        logic [NR*AW-1:0] p;
        p = '0;
        for (int i = 0; i < NR; i++) p[i*AW +: AW] = a[i];
        return p;
    endfunction

    // One full transaction; r_dly >= TO means the slave stays silent past the timeout
    task automatic run_txn(input logic [2:0] v, input int ar_dly, input int r_dly,
                           input logic [31:0] d, input logic [1:0] rs, input int g);
        logic [2:0]  oh;
        logic [2:0]  held;
        bit          to;
        int          dd;
        oh   = 3'(1) << g;
        held = v & ~oh;
        to   = (r_dly >= TO);
        dd   = to ? TO : r_dly + 1;

        @(negedge axi_clk);
        req_valid = v; req_addr = pack_addr(); arready = 1'b0; rvalid = 1'b0;
        #1;
        chk("req_ready_grant", 32'(req_ready), 32'(oh));
        chk("busy_idle", 32'(busy), 32'd0);
        chk("rsp_valid_idle", 32'(rsp_valid), 32'd0);
        chk("rsp_data_hold", rsp_data, exp_prev);

        for (int c = 0; c <= ar_dly; c++) begin
            @(negedge axi_clk);
            req_valid = held; arready = (c == ar_dly);
            rvalid = 1'($urandom_range(0, 1)); rdata = $urandom; rresp = 2'($urandom_range(0, 3));
            #1;
            chk("arvalid_addr", 32'(arvalid), 32'd1);
            chk("araddr", araddr, a[g]);
            chk("rready_addr", 32'(rready), 32'd0);
            chk("grant_id", 32'(grant_id), 32'(g));
            chk("req_ready_busy", 32'(req_ready), 32'd0);
        end

        for (int c = 0; c < dd; c++) begin
            @(negedge axi_clk);
            arready = 1'b0;
            rvalid  = (!to && c == r_dly);
            rdata   = rvalid ? d : $urandom;
            rresp   = rvalid ? rs : 2'($urandom_range(0, 3));
            #1;
            chk("rready_data", 32'(rready), 32'd1);
            chk("arvalid_data", 32'(arvalid), 32'd0);
            chk("rsp_valid_data", 32'(rsp_valid), 32'd0);
            chk("busy_data", 32'(busy), 32'd1);
        end

        @(negedge axi_clk);
        rvalid = 1'b0;
        #1;
        exp_prev = to ? 32'd0 : d;
        chk("rsp_valid", 32'(rsp_valid), 32'(oh));
        chk("rsp_data", rsp_data, exp_prev);
        chk("rsp_resp", 32'(rsp_resp), to ? 32'd2 : 32'(rs));
        chk("rready_resp", 32'(rready), 32'd0);

        if (to) begin
            for (int c = 0; c <= r_dly - TO; c++) begin
                @(negedge axi_clk);
                rvalid = (c == r_dly - TO);
                #1;
                chk("rready_drain", 32'(rready), 32'd1);
                chk("busy_drain", 32'(busy), 32'd1);
                chk("rsp_valid_drain", 32'(rsp_valid), 32'd0);
                chk("req_ready_drain", 32'(req_ready), 32'd0);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        logic [2:0] v;

        tbl[0]  = '{3'b001, 0, 0,  32'hA5A5_A5A5, 2'b00, 0};
        tbl[1]  = '{3'b010, 5, 7,  32'h1234_5678, 2'b00, 1};
        tbl[2]  = '{3'b011, 0, 0,  32'h0000_0100, 2'b00, 0};
        tbl[3]  = '{3'b011, 1, 2,  32'h0000_0101, 2'b01, 1};
        tbl[4]  = '{3'b011, 0, 0,  32'h0000_0102, 2'b00, 0};
        tbl[5]  = '{3'b011, 0, 3,  32'h0000_0103, 2'b00, 1};
        tbl[6]  = '{3'b100, 0, 0,  32'h0000_000F, 2'b11, 2};
        tbl[7]  = '{3'b111, 0, 8,  32'hDEAD_BEEF, 2'b00, 0};
        tbl[8]  = '{3'b110, 2, 12, 32'hCAFE_F00D, 2'b01, 1};
        tbl[9]  = '{3'b101, 0, 6,  32'h0BAD_C0DE, 2'b00, 2};
        tbl[10] = '{3'b111, 0, 0,  32'h7777_0000, 2'b00, 0};

        a[0] = 32'h0; a[1] = 32'h4; a[2] = 32'h8;
        resetn = 1'b0; req_valid = '0; req_addr = pack_addr();
        arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = '0;
        exp_prev = '0;
        model_reset();

        repeat (2) @(negedge axi_clk);
        #1;
        chk("rst_arvalid", 32'(arvalid), 32'd0);
        chk("rst_rready", 32'(rready), 32'd0);
        chk("rst_araddr", araddr, 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_data", rsp_data, 32'd0);
        chk("rst_rsp_resp", 32'(rsp_resp), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_grant_id", 32'(grant_id), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        @(negedge axi_clk);
        resetn = 1'b1;

        foreach (tbl[i]) begin
            model_commit(tbl[i].exp_g);
            run_txn(tbl[i].valid, tbl[i].ar_dly, tbl[i].r_dly, tbl[i].data, tbl[i].resp, tbl[i].exp_g);
        end

        // Reset during DATA: abort, no response, requester 0 wins afterwards
        v = 3'b110;
        g = model_pick(v);
        @(negedge axi_clk);
        req_valid = v; req_addr = pack_addr(); rvalid = 1'b0;
        #1;
        chk("mid_req_ready", 32'(req_ready), 32'(3'(1) << g));
        @(negedge axi_clk);
        req_valid = '0; arready = 1'b1;
        #1;
        chk("mid_arvalid", 32'(arvalid), 32'd1);
        @(negedge axi_clk);
        arready = 1'b0;
        #1;
        chk("mid_rready", 32'(rready), 32'd1);
        @(negedge axi_clk);
        resetn = 1'b0;
        @(negedge axi_clk);
        resetn = 1'b1;
        #1;
        chk("mid_rst_arvalid", 32'(arvalid), 32'd0);
        chk("mid_rst_rready", 32'(rready), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        model_reset();
        exp_prev = '0;
        model_commit(0);
        run_txn(3'b111, 0, 0, 32'h5555_AAAA, 2'b00, 0);

        for (int n = 0; n < 40; n++) begin
            v = 3'($urandom_range(1, 7));
            for (int i = 0; i < NR; i++) a[i] = $urandom;
            g = model_pick(v);
            model_commit(g);
            run_txn(v, int'($urandom_range(0, 3)), int'($urandom_range(0, 11)),
                    $urandom, 2'($urandom_range(0, 3)), g);
        end

        @(negedge axi_clk);
        req_valid = '0; rvalid = 1'b0;
        #1;
        chk("final_busy", 32'(busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/axi4_lite_read_arbiter.md
# axi4_lite_read_arbiter

Round-robin arbiter and sequencer that lets several internal read requesters share one AXI4-Lite read master port. Typical requesters are instruction fetch, data load and a debug port. It sits between the core-side requesters and the AXI4-Lite read slave (address/data channels) of the memory/peripheral interface. It runs one transaction at a time and returns data and response to the granted requester. It applies a response timeout so a silent slave cannot hang the core.

## Interface
Parameters:
- ADDRESS_WIDTH, 32, width of each request address and of araddr
- DATA_WIDTH, 32, width of rdata and rsp_data
- NUM_REQ, 2, number of requesters (2..4)
- TIMEOUT_CYCLES, 255, maximum cycles to wait for rvalid; 0 disables the timeout

Ports:
- axi_clk  input  1  clock; all logic on the rising edge
- resetn  input  1  synchronous, active-low reset
- req_valid  input  NUM_REQ  per-requester read request
- req_addr  input  NUM_REQ*ADDRESS_WIDTH  flattened addresses; requester i uses bits [i*ADDRESS_WIDTH +: ADDRESS_WIDTH]
- req_ready  output  NUM_REQ  one-hot, one-cycle pulse: request accepted
- rsp_valid  output  NUM_REQ  one-hot, one-cycle pulse: response for requester i
- rsp_data  output  DATA_WIDTH  read data; valid while any rsp_valid bit is high
- rsp_resp  output  2  AXI response code; valid while any rsp_valid bit is high
- busy  output  1  high in every state except IDLE
- grant_id  output  2  index of the current or last granted requester
- araddr  output  ADDRESS_WIDTH  AXI read address
- arvalid  output  1  AXI read address valid
- arready  input  1  AXI read address ready
- rdata  input  DATA_WIDTH  AXI read data
- rresp  input  2  AXI read response
- rvalid  input  1  AXI read data valid
- rready  output  1  AXI read data ready

## Operation
- FSM states: IDLE, ADDR, DATA, RESP, DRAIN.
- **IDLE**
  - If any req_valid bit is high, select the winner g: the first set bit searched cyclically from (last_grant+1) mod NUM_REQ.
  - Pulse req_ready[g] combinationally in this cycle.
  - On the rising edge: latch req_addr[g] into araddr, set last_grant and grant_id to g, go to ADDR.
- **ADDR**
  - Drive arvalid=1 with araddr held stable.
  - On arvalid&arready: drop arvalid and go to DATA.
  - No timeout applies in ADDR.
- **DATA**
  - Drive rready=1.
  - On rvalid: latch rdata and rresp, go to RESP.
  - Otherwise increment the wait counter. When the counter equals TIMEOUT_CYCLES (and TIMEOUT_CYCLES≠0): set the timeout flag, latch data=0 and resp=2'b10 (SLVERR), go to RESP.
- **RESP**
  - Assert rsp_valid[g] for one cycle, with rsp_data and rsp_resp driven from the latched values.
  - Next state: DRAIN if the timeout flag is set, otherwise IDLE.
- **DRAIN**
  - Drive rready=1 and discard any beat.
  - On rvalid: clear the timeout flag and go to IDLE.
- Requester obligations:
  - Hold req_valid and req_addr stable until req_ready is seen.
  - Deassert req_valid, or hold it for a new request, after acceptance.
- Requester-side responses have no backpressure. rsp_valid is a pulse that the requester must capture.
- rsp_data and rsp_resp hold their last value when rsp_valid is low.
- Only one outstanding AXI transaction exists at any time.
- Arbitration fairness:
  - The winner of one round has the lowest priority in the next.
  - A requester holding req_valid continuously is served within NUM_REQ grants.
- Unused grant_id bits are 0 when NUM_REQ≤2.

## Timing
- Reset values (resetn low at a rising edge):
  - state=IDLE; arvalid=0, rready=0, araddr=0.
  - req_ready=0, rsp_valid=0, rsp_data=0, rsp_resp=0.
  - busy=0, grant_id=0, wait counter=0, timeout flag=0.
  - last_grant=NUM_REQ-1, so requester 0 wins first.
- Reset asserted mid-transaction aborts the transaction immediately. No response pulse is issued for it. The AXI slave shares resetn.
- Minimum latency, with arready=1 and rvalid arriving the cycle after the AR handshake:
  - req_ready at cycle T
  - arvalid at T+1
  - rready at T+2; rvalid sampled at T+2
  - rsp_valid at T+3
- Back-to-back requests: the next req_ready can occur at T+4, so one transaction completes per 4 cycles at best.
- req_ready is never asserted outside IDLE. Requests arriving while busy are held off.
- Simultaneous req_valid bits in IDLE: exactly one req_ready bit is set, following the round-robin rule.
- rvalid asserted early, while the block is in ADDR, is ignored: rready=0 there.
- Timeout:
  - The counter is cleared on entry to DATA.
  - With TIMEOUT_CYCLES=N, the SLVERR response occurs after N cycles in DATA with no rvalid.
  - An rvalid in the same cycle the counter reaches N wins: the real data is returned.
- Counter width: ceil(log2(TIMEOUT_CYCLES+1)), at least 1 bit.

## Test plan
- **Single read:** req_valid=2'b01, addr 0x0, slave returns 0xA5A5A5A5 with OKAY → req_ready[0] at T, arvalid/araddr=0x0 at T+1, rsp_valid=2'b01 with rsp_data=0xA5A5A5A5 and rsp_resp=0 at T+3.
- **Contention:** both requesters hold req_valid, addresses 0x0 and 0x4 → grants alternate 0,1,0,1 across four transactions, each response routed to the matching rsp_valid bit, grant_id matches each grant.
- **Slave stalls:** arready held low 5 cycles and rvalid delayed 7 cycles → araddr and arvalid stay stable until the handshake, no req_ready pulse while busy, correct data returned.
- **Timeout:** TIMEOUT_CYCLES=8, slave never asserts rvalid → rsp_resp=2'b10 and rsp_data=0 after 8 DATA cycles. The block stays in DRAIN with busy=1. A late rvalid then returns it to IDLE with no extra rsp_valid pulse.
- **Reset mid-transaction:** resetn low during DATA → next cycle arvalid=0, rready=0, busy=0, no rsp_valid pulse. After release, requester 0 wins first.
- **Error passthrough:** slave returns rresp=2'b11 with data 0xF → rsp_resp=2'b11 and rsp_data=0xF delivered to the granted requester.
